// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: stopwatch timebase and control FSM.
// Counts MM:SS.t in BCD from a 10 Hz enable pulse. Start/stop, lap
// freeze and clear come from pre-synchronized push-button levels.
//
// Ports:
//   CLOCK_50   in   system clock (sole clock)
//   reset      in   synchronous, active-high reset
//   tick_in    in   one-cycle 10 Hz count enable
//   btn_start  in   rising edge toggles run/pause
//   btn_lap    in   rising edge toggles lap freeze
//   btn_clear  in   rising edge clears the count while paused
//   min_tens, min_ones, sec_tens, sec_ones, tenths  out  BCD display digits
//   running    out  high in RUN or LAP
//   lap_active out  high in LAP (display frozen)
//   wrapped    out  sticky rollover flag past MAX_MINUTES:59.9
module stopwatch_ctrl #(
  parameter int unsigned MAX_MINUTES = 59
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       tick_in,
  input  logic       btn_start,
  input  logic       btn_lap,
  input  logic       btn_clear,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic [3:0] tenths,
  output logic       running,
  output logic       lap_active,
  output logic       wrapped
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_LAP   = 2'd2;
  localparam logic [1:0] S_PAUSE = 2'd3;

  localparam logic [3:0] MAX_MT = 4'(MAX_MINUTES / 10);
  localparam logic [3:0] MAX_MO = 4'(MAX_MINUTES % 10);

  logic [1:0] r_state;
  logic       r_prev_start, r_prev_lap, r_prev_clear;
  logic [3:0] r_t, r_so, r_st, r_mo, r_mt;

  logic       w_edge_start, w_edge_lap, w_edge_clear;
  logic [1:0] w_next_state;
  logic       w_clear_cnt;
  logic       w_count_en;
  logic       w_wrap;
  logic [3:0] w_n_t, w_n_so, w_n_st, w_n_mo, w_n_mt;

  assign w_edge_start = btn_start & ~r_prev_start;
  assign w_edge_lap   = btn_lap   & ~r_prev_lap;
  assign w_edge_clear = btn_clear & ~r_prev_clear;
  assign w_count_en   = tick_in & ((r_state == S_RUN) | (r_state == S_LAP));

  // Priority clear > start > lap; each state only reacts to its own subset.
  always_comb begin
    w_next_state = r_state;
    w_clear_cnt  = 1'b0;
    case (r_state)
      S_IDLE:  if (w_edge_start) w_next_state = S_RUN;
      S_RUN: begin
        if (w_edge_start)    w_next_state = S_PAUSE;
        else if (w_edge_lap) w_next_state = S_LAP;
      end
      S_LAP: begin
        if (w_edge_start)    w_next_state = S_PAUSE;
        else if (w_edge_lap) w_next_state = S_RUN;
      end
      default: begin
        if (w_edge_clear) begin
          w_next_state = S_IDLE;
          w_clear_cnt  = 1'b1;
        end else if (w_edge_start) begin
          w_next_state = S_RUN;
        end
      end
    endcase
  end

  // BCD carry chain; minutes wrap to zero after MAX_MINUTES:59.9.
  always_comb begin
    w_n_t  = r_t;
    w_n_so = r_so;
    w_n_st = r_st;
    w_n_mo = r_mo;
    w_n_mt = r_mt;
    w_wrap = 1'b0;
    if (w_clear_cnt) begin
      w_n_t  = '0;
      w_n_so = '0;
      w_n_st = '0;
      w_n_mo = '0;
      w_n_mt = '0;
    end else if (w_count_en) begin
      if (r_t != 4'd9) begin
        w_n_t = r_t + 4'd1;
      end else begin
        w_n_t = '0;
        if (r_so != 4'd9) begin
          w_n_so = r_so + 4'd1;
        end else begin
          w_n_so = '0;
          if (r_st != 4'd5) begin
            w_n_st = r_st + 4'd1;
          end else begin
            w_n_st = '0;
            if ((r_mt == MAX_MT) && (r_mo == MAX_MO)) begin
              w_n_mo = '0;
              w_n_mt = '0;
              w_wrap = 1'b1;
            end else if (r_mo != 4'd9) begin
              w_n_mo = r_mo + 4'd1;
            end else begin
              w_n_mo = '0;
              w_n_mt = r_mt + 4'd1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_prev_start <= 1'b1;
      r_prev_lap   <= 1'b1;
      r_prev_clear <= 1'b1;
      r_t          <= '0;
      r_so         <= '0;
      r_st         <= '0;
      r_mo         <= '0;
      r_mt         <= '0;
      wrapped      <= 1'b0;
      running      <= 1'b0;
      lap_active   <= 1'b0;
      min_tens     <= '0;
      min_ones     <= '0;
      sec_tens     <= '0;
      sec_ones     <= '0;
      tenths       <= '0;
    end else begin
      r_state      <= w_next_state;
      r_prev_start <= btn_start;
      r_prev_lap   <= btn_lap;
      r_prev_clear <= btn_clear;
      r_t          <= w_n_t;
      r_so         <= w_n_so;
      r_st         <= w_n_st;
      r_mo         <= w_n_mo;
      r_mt         <= w_n_mt;
      if (w_clear_cnt)  wrapped <= 1'b0;
      else if (w_wrap)  wrapped <= 1'b1;
      running    <= (w_next_state == S_RUN) | (w_next_state == S_LAP);
      lap_active <= (w_next_state == S_LAP);
      // Display follows the next count except while staying in LAP; the
      // RUN->LAP edge therefore captures the count of that same cycle.
      if ((w_next_state != S_LAP) || (r_state != S_LAP)) begin
        min_tens <= w_n_mt;
        min_ones <= w_n_mo;
        sec_tens <= w_n_st;
        sec_ones <= w_n_so;
        tenths   <= w_n_t;
      end
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
module tb_stopwatch_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick_in = 1'b0;
  logic       btn_start = 1'b0;
  logic       btn_lap = 1'b0;
  logic       btn_clear = 1'b0;

  logic [3:0] a_mt, a_mo, a_st, a_so, a_t;
  logic       a_run, a_lap, a_wrap;
  logic [3:0] b_mt, b_mo, b_st, b_so, b_t;
  logic       b_run, b_lap, b_wrap;

  logic [19:0] disp_a, disp_b;
  assign disp_a = {a_mt, a_mo, a_st, a_so, a_t};
  assign disp_b = {b_mt, b_mo, b_st, b_so, b_t};

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  stopwatch_ctrl #(.MAX_MINUTES(59)) dut (
    .CLOCK_50(clk), .reset(reset), .tick_in(tick_in),
    .btn_start(btn_start), .btn_lap(btn_lap), .btn_clear(btn_clear),
    .min_tens(a_mt), .min_ones(a_mo), .sec_tens(a_st), .sec_ones(a_so),
    .tenths(a_t), .running(a_run), .lap_active(a_lap), .wrapped(a_wrap)
  );

  stopwatch_ctrl #(.MAX_MINUTES(1)) dut1 (
    .CLOCK_50(clk), .reset(reset), .tick_in(tick_in),
    .btn_start(btn_start), .btn_lap(btn_lap), .btn_clear(btn_clear),
    .min_tens(b_mt), .min_ones(b_mo), .sec_tens(b_st), .sec_ones(b_so),
    .tenths(b_t), .running(b_run), .lap_active(b_lap), .wrapped(b_wrap)
  );

  // Inputs change just after a falling edge; outputs are read there too.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; cyc(); reset = 1'b0; cyc();
  endtask

  task automatic press_start();
    btn_start = 1'b1; cyc(); btn_start = 1'b0; cyc();
  endtask

  task automatic test_reset();
    btn_start = 1'b0; btn_lap = 1'b0; btn_clear = 1'b0; tick_in = 1'b0;
    reset = 1'b1; cyc(); cyc();
    tests_run++;
    if ({disp_a, a_run, a_lap, a_wrap} !== 23'h0) begin
      tests_failed++;
      $display("FAIL reset_state got disp=%05h run=%b lap=%b wrap=%b exp 00000/0/0/0", disp_a, a_run, a_lap, a_wrap);
    end
    reset = 1'b0; cyc();
  endtask

  task automatic test_count();
    press_start();
    tests_run++;
    if (a_run !== 1'b1) begin
      tests_failed++;
      $display("FAIL start_run got running=%b exp 1", a_run);
    end
    for (int i = 0; i < 10; i++) begin
      tick_in = 1'b1; cyc(); tick_in = 1'b0;
      if (i == 9) begin
        tests_run++;
        if (disp_a !== 20'h00010) begin
          tests_failed++;
          $display("FAIL count_10_ticks got %05h exp 00010", disp_a);
        end
      end
      repeat (4) cyc();
    end
  endtask

  task automatic test_lap();
    repeat (13) begin tick_in = 1'b1; cyc(); end
    tick_in = 1'b0;
    btn_lap = 1'b1; cyc(); btn_lap = 1'b0;
    tests_run++;
    if ({disp_a, a_lap, a_run} !== {20'h00023, 2'b11}) begin
      tests_failed++;
      $display("FAIL lap_capture got %05h lap=%b run=%b exp 00023 1 1", disp_a, a_lap, a_run);
    end
    cyc();
    repeat (15) begin tick_in = 1'b1; cyc(); end
    tick_in = 1'b0; cyc();
    tests_run++;
    if ({disp_a, a_lap} !== {20'h00023, 1'b1}) begin
      tests_failed++;
      $display("FAIL lap_frozen got %05h lap=%b exp 00023 1", disp_a, a_lap);
    end
    btn_lap = 1'b1; cyc(); btn_lap = 1'b0;
    tests_run++;
    if ({disp_a, a_lap, a_run} !== {20'h00038, 2'b01}) begin
      tests_failed++;
      $display("FAIL lap_release got %05h lap=%b run=%b exp 00038 0 1", disp_a, a_lap, a_run);
    end
    cyc();
  endtask

  task automatic test_pause_tick();
    do_reset();
    press_start();
    repeat (4) begin tick_in = 1'b1; cyc(); end
    tick_in = 1'b0;
    btn_start = 1'b1; tick_in = 1'b1; cyc();
    btn_start = 1'b0; tick_in = 1'b0;
    tests_run++;
    if ({disp_a, a_run} !== {20'h00005, 1'b0}) begin
      tests_failed++;
      $display("FAIL stop_with_tick got %05h run=%b exp 00005 0", disp_a, a_run);
    end
    cyc();
    btn_start = 1'b1; tick_in = 1'b1; cyc();
    btn_start = 1'b0; tick_in = 1'b0;
    tests_run++;
    if ({disp_a, a_run} !== {20'h00005, 1'b1}) begin
      tests_failed++;
      $display("FAIL resume_with_tick got %05h run=%b exp 00005 1", disp_a, a_run);
    end
    cyc();
    tick_in = 1'b1; cyc(); tick_in = 1'b0;
    tests_run++;
    if (disp_a !== 20'h00006) begin
      tests_failed++;
      $display("FAIL resumed_count got %05h exp 00006", disp_a);
    end
  endtask

  task automatic test_clear();
    btn_clear = 1'b1; cyc(); btn_clear = 1'b0;
    tests_run++;
    if ({disp_a, a_run} !== {20'h00006, 1'b1}) begin
      tests_failed++;
      $display("FAIL clear_in_run got %05h run=%b exp 00006 1", disp_a, a_run);
    end
    cyc();
    press_start();
    tests_run++;
    if (a_run !== 1'b0) begin
      tests_failed++;
      $display("FAIL pause got running=%b exp 0", a_run);
    end
    btn_clear = 1'b1; btn_start = 1'b1; cyc();
    btn_clear = 1'b0; btn_start = 1'b0;
    tests_run++;
    if ({disp_a, a_run, a_lap} !== {20'h00000, 2'b00}) begin
      tests_failed++;
      $display("FAIL clear_over_start got %05h run=%b lap=%b exp 00000 0 0", disp_a, a_run, a_lap);
    end
    cyc();
    tick_in = 1'b1; cyc(); tick_in = 1'b0;
    tests_run++;
    if (disp_a !== 20'h00000) begin
      tests_failed++;
      $display("FAIL idle_no_count got %05h exp 00000", disp_a);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    btn_start = 1'b1; cyc();
    btn_start = 1'b0; btn_lap = 1'b1; cyc();
    btn_lap = 1'b0;
    tests_run++;
    if ({a_run, a_lap} !== 2'b11) begin
      tests_failed++;
      $display("FAIL b2b_start_lap got run=%b lap=%b exp 1 1", a_run, a_lap);
    end
    btn_start = 1'b1; cyc(); btn_start = 1'b0;
    tests_run++;
    if ({a_run, a_lap} !== 2'b00) begin
      tests_failed++;
      $display("FAIL lap_to_pause got run=%b lap=%b exp 0 0", a_run, a_lap);
    end
    cyc();
  endtask

  task automatic test_wrap();
    do_reset();
    press_start();
    tick_in = 1'b1;
    repeat (1199) cyc();
    tests_run++;
    if ({disp_b, b_wrap} !== {20'h01599, 1'b0}) begin
      tests_failed++;
      $display("FAIL preload_max got %05h wrap=%b exp 01599 0", disp_b, b_wrap);
    end
    cyc();
    tick_in = 1'b0;
    tests_run++;
    if ({disp_b, b_wrap} !== {20'h00000, 1'b1}) begin
      tests_failed++;
      $display("FAIL wrap_max1 got %05h wrap=%b exp 00000 1", disp_b, b_wrap);
    end
    tests_run++;
    if ({disp_a, a_wrap} !== {20'h02000, 1'b0}) begin
      tests_failed++;
      $display("FAIL minute_carry_max59 got %05h wrap=%b exp 02000 0", disp_a, a_wrap);
    end
    press_start();
    btn_clear = 1'b1; cyc(); btn_clear = 1'b0;
    tests_run++;
    if ({disp_b, b_wrap, b_run} !== {20'h00000, 2'b00}) begin
      tests_failed++;
      $display("FAIL clear_wrapped got %05h wrap=%b run=%b exp 00000 0 0", disp_b, b_wrap, b_run);
    end
    cyc();
  endtask

  task automatic test_held_reset();
    btn_start = 1'b1;
    reset = 1'b1; cyc(); cyc();
    reset = 1'b0;
    repeat (3) cyc();
    tests_run++;
    if (a_run !== 1'b0) begin
      tests_failed++;
      $display("FAIL held_through_reset got running=%b exp 0", a_run);
    end
    btn_start = 1'b0; cyc();
    btn_start = 1'b1; cyc();
    tests_run++;
    if (a_run !== 1'b1) begin
      tests_failed++;
      $display("FAIL repress_start got running=%b exp 1", a_run);
    end
    btn_start = 1'b0; cyc();
  endtask

  task automatic test_reset_mid_run();
    tick_in = 1'b1;
    repeat (72) cyc();
    tick_in = 1'b0;
    tests_run++;
    if ({disp_a, a_run} !== {20'h00072, 1'b1}) begin
      tests_failed++;
      $display("FAIL run_to_7_2 got %05h run=%b exp 00072 1", disp_a, a_run);
    end
    reset = 1'b1; cyc();
    tests_run++;
    if ({disp_a, a_run, a_lap, a_wrap} !== 23'h0) begin
      tests_failed++;
      $display("FAIL reset_mid_run got %05h run=%b lap=%b wrap=%b exp 00000 0 0 0", disp_a, a_run, a_lap, a_wrap);
    end
    reset = 1'b0; cyc();
    tick_in = 1'b1; cyc(); tick_in = 1'b0;
    tests_run++;
    if (disp_a !== 20'h00000) begin
      tests_failed++;
      $display("FAIL idle_after_reset got %05h exp 00000", disp_a);
    end
  endtask

  initial begin
    test_reset();
    test_count();
    test_lap();
    test_pause_tick();
    test_clear();
    test_back_to_back();
    test_wrap();
    test_held_reset();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Stopwatch timebase and control stage that sits directly downstream of the slow-tick divider.
- Consumes a one-cycle 10 Hz enable pulse on the CLOCK_50 domain and counts MM:SS.t in BCD.
- Start/stop, lap and clear controls come from synchronized push-buttons.
- BCD digits feed the seven-segment decoder stage.

Parameters:
- MAX_MINUTES, 59, highest minute value before wrap; legal range 1..99.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz, sole clock.
- reset  in  1  synchronous, active-high reset.
- tick_in  in  1  one-cycle enable pulse at 10 Hz from divider; never a clock.
- btn_start  in  1  level, active-high, pre-synchronized; rising edge toggles run/pause.
- btn_lap  in  1  level, active-high, pre-synchronized; rising edge toggles lap freeze.
- btn_clear  in  1  level, active-high, pre-synchronized; rising edge clears when paused.
- min_tens  out  4  BCD minutes tens shown on display.
- min_ones  out  4  BCD minutes ones shown on display.
- sec_tens  out  4  BCD seconds tens, 0..5.
- sec_ones  out  4  BCD seconds ones.
- tenths  out  4  BCD tenths of a second.
- running  out  1  high in RUN or LAP.
- lap_active  out  1  high in LAP; display is frozen.
- wrapped  out  1  sticky; set on rollover past MAX_MINUTES:59.9.

Behaviour:
- Single clock domain.
- All state and outputs are registered, on the rising edge of CLOCK_50.
- reset is synchronous and active-high; it wins over every other input.

Reset values:
- State = IDLE.
- All internal count digits and all displayed digits = 0.
- running = 0, lap_active = 0, wrapped = 0.
- Edge-detect history registers load 1, so a button held through reset gives no edge until it is released and pressed again.

Edge detection:
- edge_x = btn_x & ~prev_x, with prev_x updated every cycle.
- Each press produces exactly one edge cycle.

States and transitions (evaluated on current state; priority clear > start > lap):
- IDLE: start edge -> RUN. Lap and clear edges are ignored.
- RUN: start edge -> PAUSE; else lap edge -> LAP, and the live count is captured into the display registers that same cycle. Clear is ignored.
- LAP: start edge -> PAUSE, display released to live count; else lap edge -> RUN, display released to live count. Clear is ignored.
- PAUSE: clear edge -> IDLE, all count digits = 0, wrapped = 0; else start edge -> RUN. Lap is ignored.

Counting:
- Count advances only when tick_in = 1 and the current (registered) state is RUN or LAP.
- A tick in the same cycle as RUN->PAUSE is counted.
- A tick in the same cycle as PAUSE->RUN or IDLE->RUN is not counted.
- Carry chain: tenths 9->0 carries to sec_ones; sec_ones 9->0 carries to sec_tens; sec_tens 5->0 carries to minutes.
- Minutes are held as a BCD pair and increment up to MAX_MINUTES.
- At MAX_MINUTES:59.9 a tick gives 00:00.0 and sets wrapped = 1. Counting continues.
- BCD digits never hold values above 9; sec_tens never holds a value above 5.

Display path:
- In IDLE, RUN and PAUSE the outputs equal the live count, one cycle after it updates. Latency from tick_in to the output change is 1 cycle.
- In LAP the outputs hold the captured value while the internal count keeps running.

Flags:
- running and lap_active are registered decodes of the next state, so they are valid the cycle after the transition edge.
- Back-to-back edges on consecutive cycles are each honoured, since transitions are single-cycle.

Test Plan:
- Reset, then a start edge, then 10 tick_in pulses 5 cycles apart -> running = 1; outputs 00:01.0, with sec_ones = 1 and tenths = 0 one cycle after the 10th tick.
- In RUN, assert lap at count 00:02.3, then give 15 ticks -> outputs stay 00:02.3 and lap_active = 1. A second lap edge -> outputs 00:03.8 next cycle, lap_active = 0.
- Start edge and tick_in in the same cycle from RUN at 00:00.4 -> state PAUSE, count 00:00.5. Start edge and tick from PAUSE -> RUN with count still 00:00.5.
- With MAX_MINUTES = 1, preload by ticking to 01:59.9, then 1 tick -> outputs 00:00.0 and wrapped = 1. Pause, then clear -> IDLE, all zeros, wrapped = 0.
- Clear edge in RUN, and clear with start in the same cycle in PAUSE -> RUN ignores clear. PAUSE goes to IDLE with zeros, because clear has priority over start.
- btn_start held high across reset, then released and pressed -> no transition while held; a single RUN transition on the re-press. Reset asserted mid-RUN at 00:07.2 -> all outputs 0 and IDLE on the next edge.
